// File: rtl/spi_pkg.sv
// Shared types and default sizing for the single-byte SPI master.
package spi_pkg;

    localparam int SPI_DATA_W = 8;
    localparam int SPI_DIV_W  = 26;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

endpackage

// File: rtl/spi_clk_div.sv
// SCLK half-period divider: loads N on acceptance, then ticks once every N
// enabled cycles. A requested N of 0 behaves as N = 1.
module spi_clk_div #(
    parameter int DIV_W = spi_pkg::SPI_DIV_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [DIV_W-1:0] n_in,
    input  logic             en,
    output logic             tick
);

    logic [DIV_W-1:0] reload_q, reload_d;
    logic [DIV_W-1:0] cnt_q,    cnt_d;

    // Count from N-1 down to 0 so the full DIV_W range is usable without wrapping.
    always_comb begin
        // NOTE: defaults first so every path assigns every _d signal and no latch is inferred.
        reload_d = reload_q;
        cnt_d    = cnt_q;
        if (load) begin
            reload_d = (n_in == '0) ? '0 : n_in - DIV_W'(1);
            cnt_d    = (n_in == '0) ? '0 : n_in - DIV_W'(1);
        end else if (en) begin
            cnt_d = (cnt_q == '0) ? reload_q : cnt_q - DIV_W'(1);
        end
    end

    assign tick = en && (cnt_q == '0);

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops update together.
        if (reset) begin
            reload_q <= '0;
            cnt_q    <= '0;
        end else begin
            reload_q <= reload_d;
            cnt_q    <= cnt_d;
        end
    end

endmodule

// File: rtl/spi_byte_master.sv
// Transmit-only SPI mode-0 master sending one byte per transfer under CS.
// Define SPI_LSB_FIRST_EN to shift LSB first; otherwise MSB first.
module spi_byte_master
    import spi_pkg::*;
#(
    parameter int DATA_W = SPI_DATA_W,
    parameter int DIV_W  = SPI_DIV_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              start,
    input  logic [DIV_W-1:0]  div_factor,
    output logic              mosi,
    output logic              sclk,
    output logic              cs,
    output logic [DATA_W-1:0] data_out,
    output logic              busy,
    output logic              avail
);

    localparam int CNT_W = $clog2(DATA_W + 1);

    state_t             state_q, state_d;
    logic [DATA_W-1:0]  shreg_q, shreg_d;
    logic [DATA_W-1:0]  echo_q, echo_d;
    logic [DATA_W-1:0]  data_out_q, data_out_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic               mosi_q, mosi_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               busy_q, busy_d;
    logic               avail_q, avail_d;

    logic               accept;
    logic               tick;
    logic               last_fall;
    logic               first_bit;
    logic               next_bit;
    logic [DATA_W-1:0]  shreg_next;
    logic [DATA_W-1:0]  echo_next;

    assign accept    = (state_q == IDLE) && start;
    assign last_fall = tick && sclk_q && (bit_cnt_q == CNT_W'(DATA_W - 1));

    // Echo shifts in the same order as the wire so it ends up in original bit order.
`ifdef SPI_LSB_FIRST_EN
    assign first_bit  = data_in[0];
    assign next_bit   = shreg_q[1];
    assign shreg_next = shreg_q >> 1;
    assign echo_next  = {mosi_q, echo_q[DATA_W-1:1]};
`else
    assign first_bit  = data_in[DATA_W-1];
    assign next_bit   = shreg_q[DATA_W-2];
    assign shreg_next = shreg_q << 1;
    assign echo_next  = {echo_q[DATA_W-2:0], mosi_q};
`endif

    spi_clk_div #(
        .DIV_W (DIV_W)
    ) u_clk_div (
        .clk   (clk),
        .reset (reset),
        .load  (accept),
        .n_in  (div_factor),
        .en    (state_q == SHIFT),
        .tick  (tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (start) state_d = SHIFT;
            SHIFT:   if (last_fall) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        shreg_d    = shreg_q;
        echo_d     = echo_q;
        data_out_d = data_out_q;
        bit_cnt_d  = bit_cnt_q;
        mosi_d     = mosi_q;
        sclk_d     = sclk_q;
        cs_d       = cs_q;
        busy_d     = busy_q;
        avail_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    shreg_d   = data_in;
                    echo_d    = '0;
                    bit_cnt_d = '0;
                    mosi_d    = first_bit;
                    sclk_d    = 1'b0;
                    cs_d      = 1'b0;
                    busy_d    = 1'b1;
                end
            end
            SHIFT: begin
                if (tick) begin
                    sclk_d = ~sclk_q;
                    if (!sclk_q) begin
                        echo_d = echo_next;
                    end else if (last_fall) begin
                        cs_d = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        shreg_d   = shreg_next;
                        mosi_d    = next_bit;
                    end
                end
            end
            DONE: begin
                cs_d       = 1'b1;
                sclk_d     = 1'b0;
                mosi_d     = 1'b0;
                busy_d     = 1'b0;
                avail_d    = 1'b1;
                data_out_d = echo_q;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_q    <= '0;
            echo_q     <= '0;
            data_out_q <= '0;
            bit_cnt_q  <= '0;
            mosi_q     <= 1'b0;
            sclk_q     <= 1'b0;
            cs_q       <= 1'b1;
            busy_q     <= 1'b0;
            avail_q    <= 1'b0;
        end else begin
            shreg_q    <= shreg_d;
            echo_q     <= echo_d;
            data_out_q <= data_out_d;
            bit_cnt_q  <= bit_cnt_d;
            mosi_q     <= mosi_d;
            sclk_q     <= sclk_d;
            cs_q       <= cs_d;
            busy_q     <= busy_d;
            avail_q    <= avail_d;
        end
    end

    assign mosi     = mosi_q;
    assign sclk     = sclk_q;
    assign cs       = cs_q;
    assign data_out = data_out_q;
    assign busy     = busy_q;
    assign avail    = avail_q;

endmodule

// File: tb/tb_spi_byte_master.sv
// Directed bench for spi_byte_master: reset, single transfers, N=0, held-start
// handshake, mid-transfer reset and ignored mid-transfer input changes.
module tb_spi_byte_master;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  data_in;
    logic        start;
    logic [25:0] div_factor;
    logic        mosi;
    logic        sclk;
    logic        cs;
    logic [7:0]  data_out;
    logic        busy;
    logic        avail;

    int errors = 0;
    int checks = 0;

    spi_byte_master dut (
        .clk        (clk),
        .reset      (reset),
        .data_in    (data_in),
        .start      (start),
        .div_factor (div_factor),
        .mosi       (mosi),
        .sclk       (sclk),
        .cs         (cs),
        .data_out   (data_out),
        .busy       (busy),
        .avail      (avail)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Byte as it appears on the wire, collected MSB-first by the bench.
    function automatic logic [7:0] wire_order(input logic [7:0] b);
`ifdef SPI_LSB_FIRST_EN
        logic [7:0] r;
        for (int i = 0; i < 8; i++) r[i] = b[7-i];
        return r;
`else
        return b;
`endif
    endfunction

    // Observes one frame starting at the accept edge (j = 0); returns at the avail sample.
    task automatic capture(input bit hold, input bit disturb, input int max_j,
                           output int cs_low, output logic [7:0] rx,
                           output int first_rise, output int rises, output int avail_at);
        logic prev_sclk;
        bit   cs_run;
        cs_low = 0; rx = '0; first_rise = -1; rises = 0; avail_at = -1;
        prev_sclk = 1'b0; cs_run = 1'b1;
        for (int j = 0; j <= max_j; j++) begin
            step();
            if (j == 0 && !hold) start = 1'b0;
            if (disturb && j == 5) begin
                data_in    = 8'hFF;
                div_factor = 26'd7;
            end
            if (disturb && j == 12) start = 1'b1;
            if (disturb && j == 13) start = 1'b0;
            if (cs_run && cs === 1'b0) cs_low++;
            else cs_run = 1'b0;
            if (sclk === 1'b1 && prev_sclk === 1'b0) begin
                rises++;
                rx = {rx[6:0], mosi};
                if (first_rise < 0) first_rise = j;
            end
            prev_sclk = sclk;
            if (avail === 1'b1) begin
                avail_at = j;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; data_in = 8'h00; div_factor = 26'd0;
        repeat (3) step();
        checks++;
        if ({cs, sclk, mosi, busy, avail, data_out} !== {5'b10000, 8'h00}) begin
            errors++;
            $display("FAIL reset_held: got cs=%b sclk=%b mosi=%b busy=%b avail=%b data_out=%h want 1 0 0 0 0 00",
                     cs, sclk, mosi, busy, avail, data_out);
        end
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            checks++;
            if ({cs, sclk, mosi, busy, avail, data_out} !== {5'b10000, 8'h00}) begin
                errors++;
                $display("FAIL idle_%0d: got cs=%b sclk=%b mosi=%b busy=%b avail=%b data_out=%h want 1 0 0 0 0 00",
                         i, cs, sclk, mosi, busy, avail, data_out);
            end
        end
    endtask

    // One pulsed-start transfer with full timing checks.
    task automatic run_single(input string name, input logic [7:0] b, input logic [25:0] div,
                              input int n, input bit disturb);
        int cs_low, first_rise, rises, avail_at;
        logic [7:0] rx;
        data_in = b; div_factor = div; start = 1'b1;
        capture(1'b0, disturb, 16 * n + 20, cs_low, rx, first_rise, rises, avail_at);
        checks++;
        if (cs_low !== 16 * n) begin
            errors++; $display("FAIL %s_cs_low: got %0d want %0d", name, cs_low, 16 * n);
        end
        checks++;
        if (rx !== wire_order(b) || rises !== 8) begin
            errors++; $display("FAIL %s_mosi: got %h (%0d rises) want %h (8 rises)", name, rx, rises, wire_order(b));
        end
        checks++;
        if (first_rise !== n) begin
            errors++; $display("FAIL %s_first_rise: got %0d want %0d", name, first_rise, n);
        end
        checks++;
        if (avail_at !== 16 * n + 1) begin
            errors++; $display("FAIL %s_avail_at: got %0d want %0d", name, avail_at, 16 * n + 1);
        end
        checks++;
        if ({data_out, busy, cs, sclk, mosi} !== {b, 4'b0100}) begin
            errors++;
            $display("FAIL %s_done: got data_out=%h busy=%b cs=%b sclk=%b mosi=%b want %h 0 1 0 0",
                     name, data_out, busy, cs, sclk, mosi, b);
        end
        step();
        checks++;
        if ({avail, cs, busy} !== 3'b010) begin
            errors++; $display("FAIL %s_after: got avail=%b cs=%b busy=%b want 0 1 0", name, avail, cs, busy);
        end
    endtask

    task automatic test_basic();
        run_single("a5_div2", 8'hA5, 26'd2, 2, 1'b0);
    endtask

    task automatic test_div_zero();
        run_single("c3_div0", 8'hC3, 26'd0, 1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [7:0] hs_bytes [18] = '{8'h0C, 8'h01, 8'h09, 8'h00, 8'h0A, 8'h0F, 8'h0B, 8'h07, 8'h0F,
                                      8'h00, 8'h01, 8'h81, 8'h02, 8'h42, 8'h03, 8'h24, 8'h04, 8'h18};
        int cs_low, first_rise, rises, avail_at, frames, stray;
        logic [7:0] rx;
        frames = 0;
        data_in = hs_bytes[0]; div_factor = 26'd3; start = 1'b1;
        for (int i = 0; i < 18; i++) begin
            capture(1'b1, 1'b0, 80, cs_low, rx, first_rise, rises, avail_at);
            if (avail_at >= 0) frames++;
            checks++;
            if (cs_low !== 48 || rx !== wire_order(hs_bytes[i]) || avail_at !== 49 || data_out !== hs_bytes[i]) begin
                errors++;
                $display("FAIL hs_frame_%0d: got cs_low=%0d rx=%h avail_at=%0d data_out=%h want 48 %h 49 %h",
                         i, cs_low, rx, avail_at, data_out, wire_order(hs_bytes[i]), hs_bytes[i]);
            end
            if (i < 17) data_in = hs_bytes[i+1];
            else start = 1'b0;
        end
        stray = 0;
        for (int i = 0; i < 30; i++) begin
            step();
            if (cs !== 1'b1 || avail !== 1'b0) stray++;
        end
        checks++;
        if (frames !== 18 || stray !== 0) begin
            errors++; $display("FAIL hs_count: got frames=%0d stray=%0d want 18 0", frames, stray);
        end
    endtask

    task automatic test_reset_abort();
        int toggles, stray;
        logic prev;
        data_in = 8'h5A; div_factor = 26'd2; start = 1'b1;
        step();
        start = 1'b0;
        toggles = 0; prev = sclk;
        for (int j = 0; j < 40; j++) begin
            step();
            if (sclk !== prev) toggles++;
            prev = sclk;
            if (toggles == 5) break;
        end
        checks++;
        if (toggles !== 5) begin
            errors++; $display("FAIL abort_reach_edge5: got %0d toggles want 5", toggles);
        end
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({cs, sclk, busy, avail, mosi} !== 5'b10000) begin
            errors++;
            $display("FAIL abort_state: got cs=%b sclk=%b busy=%b avail=%b mosi=%b want 1 0 0 0 0",
                     cs, sclk, busy, avail, mosi);
        end
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (avail !== 1'b0 || cs !== 1'b1) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL abort_no_avail: got %0d bad cycles want 0", stray);
        end
        run_single("after_abort", 8'h3C, 26'd1, 1, 1'b0);
    endtask

    task automatic test_ignore_changes();
        int stray;
        run_single("disturbed", 8'h96, 26'd2, 2, 1'b1);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (cs !== 1'b1 || avail !== 1'b0 || busy !== 1'b0) stray++;
        end
        checks++;
        if (stray !== 0) begin
            errors++; $display("FAIL disturbed_no_extra: got %0d active cycles want 0", stray);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div_zero();
        test_back_to_back();
        test_reset_abort();
        test_ignore_changes();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
